// File: rtl/regfile_dbg_pkg.sv
// Shared types and default sizes for the register-file debug dump controller.
// Both the RTL and any block that talks to the dump port import this package.
package regfile_dbg_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 16;
    localparam int PC_IDX = 15;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_word_t;

    typedef enum logic [2:0] {
        IDLE,
        FREEZE,
        READ,
        SEND,
        DONE,
        ABORT
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Freezes the core, walks register-file port A over R0..R(NREGS-1), substitutes the PC
// for PC_IDX and streams each word with its index over a valid/ready port.
module regfile_dump_ctrl
    import regfile_dbg_pkg::*;
#(
    parameter int DATA_W = regfile_dbg_pkg::DATA_W,
    parameter int ADDR_W = regfile_dbg_pkg::ADDR_W,
    parameter int NREGS  = regfile_dbg_pkg::NREGS,
    parameter int PC_IDX = regfile_dbg_pkg::PC_IDX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall_ack,
    output logic [ADDR_W-1:0] rf_dir,
    input  logic [DATA_W-1:0] rf_do,
    input  logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              dbg_freeze,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] PcIdx   = ADDR_W'(PC_IDX);

    dump_state_t       state;
    dump_state_t       nextState;
    logic [ADDR_W-1:0] idx;
    logic              handshake;

    assign handshake = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Losing stall_ack while the port is in use takes priority over everything else,
    // because the register file may already be changing under us.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = FREEZE;
            FREEZE:  if (stall_ack) nextState = READ;
            READ:    nextState = stall_ack ? SEND : ABORT;
            SEND: begin
                if (!stall_ack) begin
                    nextState = ABORT;
                end else if (handshake) begin
                    nextState = (idx == LastIdx) ? DONE : READ;
                end
            end
            DONE:    nextState = IDLE;
            ABORT:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) idx <= '0;
                end
                READ: begin
                    if (stall_ack) begin
                        out_data  <= (idx == PcIdx) ? pc : rf_do;
                        out_idx   <= idx;
                        out_last  <= (idx == LastIdx);
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (!stall_ack) begin
                        out_valid <= 1'b0;
                    end else if (handshake) begin
                        out_valid <= 1'b0;
                        if (idx != LastIdx) idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address stays on idx through SEND so rf_dir is stable while the sink stalls.
    assign rf_dir     = (state == READ || state == SEND) ? idx : '0;
    assign dbg_freeze = (state == FREEZE) || (state == READ) || (state == SEND);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE) || (state == ABORT);
    assign err        = (state == ABORT);

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Randomised scoreboard bench for regfile_dump_ctrl: a behavioural register file feeds
// port A, expected beats are queued at start and popped by an independent monitor.
module tb_regfile_dump_ctrl;

    localparam int NREGS  = 16;
    localparam int PC_IDX = 15;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stall_ack = 1'b1;
    logic [4:0]  rf_dir;
    logic [31:0] rf_do;
    logic [31:0] pc = '0;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        dbg_freeze;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] rfMem [32];
    beat_t       expQ[$];
    logic        errQ[$];
    beat_t       monBeat;
    logic        monErr;
    int          checks = 0;
    int          passes = 0;
    bit          readyRandom = 1'b0;
    bit          readyHold = 1'b0;
    bit          found;

    regfile_dump_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stall_ack(stall_ack),
        .rf_dir(rf_dir), .rf_do(rf_do), .pc(pc),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .dbg_freeze(dbg_freeze),
        .busy(busy), .done(done), .err(err)
    );

    assign rf_do = rfMem[rf_dir];

    always #5 clk = ~clk;

    // Sink model: updates after the stimulus has settled for the cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = readyHold ? 1'b0 : (readyRandom ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Monitor: every accepted beat and every done pulse is matched against the queues.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpectedBeat: got idx %0d data %0h, required no beat", out_idx, out_data);
            end else begin
                monBeat = expQ.pop_front();
                checkOutput("beatIdx", 32'(out_idx), 32'(monBeat.idx));
                checkOutput("beatData", out_data, monBeat.data);
                checkOutput("beatLast", 32'(out_last), 32'(monBeat.last));
            end
        end
        if (rst && done) begin
            if (errQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpectedDone: got done err=%0d, required no done", err);
            end else begin
                monErr = errQ.pop_front();
                checkOutput("doneErr", 32'(err), 32'(monErr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeReg(input int addr, input logic [31:0] data);
        rfMem[addr] = data;
    endtask

    task automatic randomiseRegs();
        for (int i = 0; i < NREGS - 1; i++) writeReg(i, $urandom);
        pc = $urandom;
    endtask

    // The reference model: the first nBeats registers in index order, PC in its slot.
    task automatic pushDump(input int nBeats, input logic expErr);
        beat_t b;
        for (int k = 0; k < nBeats; k++) begin
            b.idx  = k;
            b.data = (k == PC_IDX) ? pc : rfMem[k];
            b.last = (k == NREGS - 1);
            expQ.push_back(b);
        end
        errQ.push_back(expErr);
    endtask

    task automatic applyStimulus(input int nBeats, input logic expErr, input logic holdStart);
        pushDump(nBeats, expErr);
        start = 1'b1;
        tick();
        if (!holdStart) start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) break;
        end
        if (n == budget) begin
            checks++;
            $display("[TB] FAIL doneTimeout: got no done in %0d cycles, required done", budget);
        end
        tick();
    endtask

    task automatic waitBeat(input int k, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            tick();
            if (out_valid && out_idx == 5'(k)) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            $display("[TB] FAIL beatTimeout: got no beat idx %0d, required one", k);
        end
    endtask

    task automatic checkDrained();
        checkOutput("beatsDrained", 32'(expQ.size()), 32'd0);
        checkOutput("donesDrained", 32'(errQ.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rfMem[i] = '0;
        repeat (2) @(negedge clk);
        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstFreeze", 32'(dbg_freeze), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstErr", 32'(err), 32'd0);
        checkOutput("rstDir", 32'(rf_dir), 32'd0);
        rst = 1'b1;
        tick();

        // Asynchronous reset in the middle of SEND of register 3.
        randomiseRegs();
        applyStimulus(16, 1'b0, 1'b0);
        waitBeat(3, found);
        readyHold = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midRstValid", 32'(out_valid), 32'd0);
        checkOutput("midRstFreeze", 32'(dbg_freeze), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstDone", 32'(done), 32'd0);
        checkOutput("midRstErr", 32'(err), 32'd0);
        checkOutput("beatsBeforeRst", 32'(expQ.size()), 32'd13);
        expQ.delete();
        errQ.delete();
        readyHold = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("postRstBusy", 32'(busy), 32'd0);
        checkOutput("postRstDir", 32'(rf_dir), 32'd0);
        tick();

        // Full dump with exact cycle timeline.
        for (int i = 0; i < 32; i++) writeReg(i, 32'd0);
        writeReg(7, 32'd21);
        writeReg(10, 32'd55);
        pc = 32'd8;
        applyStimulus(16, 1'b0, 1'b0);
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            checkOutput($sformatf("freezeCyc%0d", c), 32'(dbg_freeze), 32'(c <= 33));
            checkOutput($sformatf("doneCyc%0d", c), 32'(done), 32'(c == 34));
            tick();
        end
        checkDrained();

        // Backpressure on register 7.
        randomiseRegs();
        applyStimulus(16, 1'b0, 1'b0);
        waitBeat(7, found);
        readyHold = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("holdValid", 32'(out_valid), 32'd1);
            checkOutput("holdData", out_data, rfMem[7]);
            checkOutput("holdIdx", 32'(out_idx), 32'd7);
            checkOutput("holdDir", 32'(rf_dir), 32'd7);
        end
        readyHold = 1'b0;
        waitBeat(8, found);
        waitDone(200);
        checkDrained();

        // Slow freeze acknowledge.
        stall_ack = 1'b0;
        randomiseRegs();
        applyStimulus(16, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("slowFreeze", 32'(dbg_freeze), 32'd1);
            checkOutput("slowValid", 32'(out_valid), 32'd0);
            tick();
        end
        stall_ack = 1'b1;
        @(negedge clk);
        checkOutput("ackCycValid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("readCycValid", 32'(out_valid), 32'd0);
        checkOutput("readCycDir", 32'(rf_dir), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("firstSendValid", 32'(out_valid), 32'd1);
        checkOutput("firstSendIdx", 32'(out_idx), 32'd0);
        waitDone(200);
        checkDrained();

        // Abort while register 4 is being offered.
        randomiseRegs();
        applyStimulus(4, 1'b1, 1'b0);
        waitBeat(4, found);
        readyHold = 1'b1;
        stall_ack = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("abortValid", 32'(out_valid), 32'd0);
        checkOutput("abortFreeze", 32'(dbg_freeze), 32'd0);
        checkOutput("abortDone", 32'(done), 32'd1);
        checkOutput("abortErr", 32'(err), 32'd1);
        tick();
        @(negedge clk);
        checkOutput("afterAbortDone", 32'(done), 32'd0);
        checkOutput("afterAbortErr", 32'(err), 32'd0);
        checkOutput("afterAbortBusy", 32'(busy), 32'd0);
        stall_ack = 1'b1;
        readyHold = 1'b0;
        tick();
        checkDrained();

        // Start pulse while busy is ignored.
        randomiseRegs();
        applyStimulus(16, 1'b0, 1'b0);
        waitBeat(9, found);
        start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(200);
        @(negedge clk);
        checkOutput("noRestart", 32'(busy), 32'd0);
        tick();
        checkDrained();

        // Start held through DONE restarts on the first IDLE cycle.
        randomiseRegs();
        pushDump(16, 1'b0);
        applyStimulus(16, 1'b0, 1'b1);
        waitDone(200);
        @(negedge clk);
        checkOutput("idleBetween", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        @(negedge clk);
        checkOutput("restartFreeze", 32'(dbg_freeze), 32'd1);
        waitDone(200);
        checkDrained();

        // Randomised dumps under random sink backpressure.
        readyRandom = 1'b1;
        for (int r = 0; r < 4; r++) begin
            randomiseRegs();
            applyStimulus(16, 1'b0, 1'b0);
            waitDone(400);
            checkDrained();
        end
        readyRandom = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump_ctrl.md
Name: regfile_dump_ctrl

Overview:
Debug reader on the register-file read side. On a start request it freezes the core and reads R0..R14 through read port A. It takes R15 from the PC input and streams all 16 words out over a valid/ready interface, one word per beat with its register index. At top level, dirA is muxed to rf_dir while dbg_freeze is high.

Parameters:
DATA_W, 32, register/data width
ADDR_W, 5, register address width (matches dirA/dirB/dirWR)
NREGS, 16, number of registers dumped (indices 0..NREGS-1)
PC_IDX, 15, index whose value comes from pc instead of rf_do

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  dump request; sampled only in IDLE
stall_ack  in  1  core confirms it is frozen; must stay high for the whole dump
rf_dir  out  ADDR_W  read address to register-file port A
rf_do  in  DATA_W  register-file port A data; combinational from rf_dir
pc  in  DATA_W  current r15/PC value
out_data  out  DATA_W  dumped word
out_idx  out  ADDR_W  register index of out_data
out_valid  out  1  beat valid
out_ready  in  1  sink accepts the beat
out_last  out  1  high with the beat where out_idx == NREGS-1
dbg_freeze  out  1  request core stall / dirA mux select
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at dump end
err  out  1  one-cycle pulse with done when the dump was aborted

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous, active-low.
- Reset values: rst=0 forces state IDLE, idx=0, and every output to 0 immediately, without waiting for a clock edge. This applies mid-dump too: dbg_freeze drops asynchronously.
- FSM states: IDLE, FREEZE, READ, SEND, DONE, ABORT. All outputs are registered or decoded from the state register (Moore); none depend combinationally on inputs.
- IDLE: start=1 -> FREEZE, idx<=0. start=0 -> remain in IDLE.
- FREEZE: dbg_freeze=1. stall_ack=1 -> READ. Otherwise wait indefinitely.
- READ: rf_dir=idx.
  - Capture on the clock edge: out_data <= (idx==PC_IDX) ? pc : rf_do.
  - Also on that edge: out_idx <= idx, out_last <= (idx==NREGS-1), out_valid <= 1.
  - Next state: SEND.
- SEND: out_valid=1. out_data, out_idx, out_last and rf_dir are held stable until out_ready=1.
  - On handshake (out_valid & out_ready): out_valid <= 0.
  - If idx==NREGS-1 -> DONE. Otherwise idx <= idx+1 -> READ.
- DONE: dbg_freeze=0, done=1 for one cycle -> IDLE.
- ABORT: dbg_freeze=0, done=1, err=1 for one cycle -> IDLE.
- Throughput: one beat per 2 cycles maximum. With stall_ack=1 and out_ready=1 throughout, the timeline relative to start sampled in cycle 0 is:
  - cycle 1: FREEZE
  - cycle 2+2k: READ of register k
  - cycle 3+2k: SEND of register k
  - cycle 34: DONE
  - cycle 35: IDLE
- dbg_freeze is high in FREEZE, READ and SEND only.
- stall_ack falls while in READ or SEND -> next state ABORT. out_valid is cleared in the same edge; the partially sent beat is dropped. This is the only case where out_valid falls without a handshake.
- start while busy: ignored, not queued. If start is held high through DONE, a new dump begins on the first IDLE cycle.
- idx width is ADDR_W with no wrap beyond NREGS-1. NREGS must be <= 2^ADDR_W.
- The block never writes the register file; REG_WR stays owned by the core.

Decomposition:
- Package regfile_dbg_pkg holds: the state enum (dump_state_t), DATA_W, ADDR_W, NREGS and PC_IDX defaults, and the typedefs reg_addr_t and reg_word_t.
- No sub-module: the FSM, index counter and output register fit in one module.

Test Plan:
1. Reset: rst=0 mid-SEND at idx 3 -> out_valid, dbg_freeze, busy, done and err read 0 before the next clk edge; after release the block sits in IDLE with rf_dir=0.
2. Full dump: R7=21, R10=55 written via REG_WR/dirWR/di beforehand, pc=32'd8, stall_ack=1, out_ready=1, start pulsed in cycle 0.
   - 16 beats with out_idx 0..15.
   - Beat 7 carries 21, beat 10 carries 55, beat 15 carries 8 with out_last=1; all other beats carry 0.
   - done=1 only in cycle 34; dbg_freeze high in cycles 1..33.
3. Backpressure: out_ready=0 for 5 cycles at idx 7 -> out_valid stays 1; out_data=21, out_idx=7 and rf_dir=7 all stable; idx 8 is read only after the handshake.
4. Slow freeze: stall_ack rises 3 cycles after dbg_freeze -> block stays in FREEZE with out_valid=0; the first READ occurs the cycle after stall_ack=1.
5. Abort: stall_ack drops during SEND of idx 4 -> next cycle out_valid=0, dbg_freeze=0, done=1 and err=1 for one cycle, then IDLE; no beats with idx >= 4 are accepted.
6. Start while busy: start pulsed at idx 9 -> no effect, 16 beats total; start held high through DONE -> a second dump starts at the first IDLE cycle with out_idx=0.
